// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver/transmitter types and default constants
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_SB_TICK    = 16;
  localparam int UART_MID_SAMPLE = UART_OVERSAMPLE / 2 - 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } uart_state_t;

  // Tick index that lands on the middle of a bit period.
  function automatic int mid_sample(input int oversample);
    return oversample / 2 - 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with framing-error and break handling
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int SB_TICK    = UART_SB_TICK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int SW = $clog2((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] MID_S  = SW'(mid_sample(OVERSAMPLE));
  localparam logic [SW-1:0] LAST_S = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] LAST_B = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] LAST_N = NW'(DATA_BITS - 1);

  uart_state_t          state, state_n;
  logic [SW-1:0]        s_cnt, s_cnt_n;
  logic [NW-1:0]        n_cnt, n_cnt_n;
  logic [DATA_BITS-1:0] sreg, sreg_n;
  logic [DATA_BITS-1:0] dout_n;
  logic                 done_n, ferr_n;
  logic                 rx_sync;

  // Line idles high, so the synchroniser must come out of reset as 1.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_sync)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n_cnt        <= '0;
      sreg         <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      s_cnt        <= s_cnt_n;
      n_cnt        <= n_cnt_n;
      sreg         <= sreg_n;
      dout         <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    sreg_n  = sreg;
    dout_n  = dout;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_n = START;
          s_cnt_n = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == MID_S) begin
            if (!rx_sync) begin
              state_n = DATA;
              s_cnt_n = '0;
              n_cnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == LAST_S) begin
            sreg_n  = {rx_sync, sreg[DATA_BITS-1:1]};
            s_cnt_n = '0;
            if (n_cnt == LAST_N) state_n = STOP;
            else                 n_cnt_n = n_cnt + NW'(1);
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == LAST_B) begin
            if (rx_sync) begin
              dout_n  = sreg;
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = BRK_WAIT;
            end
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
      // A held-low line must return high before another start is accepted.
      BRK_WAIT: begin
        if (rx_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx, default and 7-bit/2-stop variants
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx2 = 1'b1;
  logic [7:0] dout;
  logic [6:0] dout2;
  logic       rx_done_tick, frame_err, busy;
  logic       rx_done_tick2, frame_err2, busy2;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_num = 0;
  int fall_tick = 0;
  int done2_tick = 0;
  int ferr_cnt = 0;
  int ferr2_cnt = 0;
  int overlap_cnt = 0;
  int done_busy_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [6:0] exp2_q[$];
  logic [6:0] got2_q[$];

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  uart_rx #(.DATA_BITS(7), .OVERSAMPLE(16), .SB_TICK(32)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .rx           (rx2),
    .dout         (dout2),
    .rx_done_tick (rx_done_tick2),
    .frame_err    (frame_err2),
    .busy         (busy2)
  );

  always #5 clk = ~clk;

  // Scaled-down baud: one tick every 4 clk keeps the run short.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      tick_num = tick_num + 1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick) begin
      got_q.push_back(dout);
      if (busy) done_busy_cnt <= done_busy_cnt + 1;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_done_tick && frame_err) overlap_cnt <= overlap_cnt + 1;
    if (rx_done_tick2) begin
      got2_q.push_back(dout2);
      done2_tick <= tick_num;
    end
    if (frame_err2) ferr2_cnt <= ferr2_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    #1;
    if (sel) rx2 = v;
    else     rx  = v;
  endtask

  task automatic send_bits(input bit sel, input logic [8:0] data, input int nbits);
    drive(sel, 1'b0);
    fall_tick = tick_num;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      drive(sel, data[i]);
      wait_ticks(16);
    end
  endtask

  task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                            input int stop_ticks);
    if (sel) exp2_q.push_back(data[6:0]);
    else     exp_q.push_back(data[7:0]);
    send_bits(sel, data, nbits);
    drive(sel, 1'b1);
    wait_ticks(stop_ticks);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %0h want 00", dout); end
    n_cmp++;
    if ({rx_done_tick, frame_err, busy} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {rx_done_tick, frame_err, busy});
    end
    n_cmp++;
    if (dout2 !== 7'h00) begin n_bad++; $display("FAIL reset_dout2: got %0h want 00", dout2); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, busy2} !== 2'b00) begin n_bad++; $display("FAIL reset_release_busy: got %b want 00", {busy, busy2}); end
    repeat (4) @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_glitch;
    wait_ticks(1);
    drive(0, 1'b0);
    wait_ticks(4);
    drive(0, 1'b1);
    wait_ticks(2);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    wait_ticks(6);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_idle: got %b want 0", busy); end
    n_cmp++;
    if (got_q.size() != 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d want 0", got_q.size()); end
    n_cmp++;
    if (dout !== 8'h00) begin n_bad++; $display("FAIL glitch_dout: got %0h want 00", dout); end
  endtask

  task automatic test_valid;
    logic [7:0] g, e;
    wait_ticks(1);
    send_frame(0, 9'h0A5, 8, 16);
    wait_ticks(2);
    n_cmp++;
    if (got_q.size() != 1) begin n_bad++; $display("FAIL valid_pulses: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL valid_data: got %0h want %0h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    n_cmp++;
    if (ferr_cnt != 0) begin n_bad++; $display("FAIL valid_ferr: got %0d want 0", ferr_cnt); end
    n_cmp++;
    if (done_busy_cnt != 0) begin n_bad++; $display("FAIL valid_busy_at_done: got %0d want 0", done_busy_cnt); end
    n_cmp++;
    if (dout !== 8'hA5) begin n_bad++; $display("FAIL valid_dout_hold: got %0h want a5", dout); end
  endtask

  task automatic test_framing;
    logic [7:0] g, e;
    wait_ticks(1);
    send_bits(0, 9'h03C, 8);
    drive(0, 1'b0);
    wait_ticks(48);
    #1;
    n_cmp++;
    if (ferr_cnt != 1) begin n_bad++; $display("FAIL frame_err_count: got %0d want 1", ferr_cnt); end
    n_cmp++;
    if (got_q.size() != 0) begin n_bad++; $display("FAIL frame_pulses: got %0d want 0", got_q.size()); end
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL frame_busy_break: got %b want 1", busy); end
    n_cmp++;
    if (dout !== 8'hA5) begin n_bad++; $display("FAIL frame_dout_kept: got %0h want a5", dout); end
    drive(0, 1'b1);
    wait_ticks(2);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL frame_busy_release: got %b want 0", busy); end
    send_frame(0, 9'h05A, 8, 16);
    wait_ticks(2);
    n_cmp++;
    if (got_q.size() != 1) begin n_bad++; $display("FAIL frame_next_pulses: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL frame_next_data: got %0h want %0h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    n_cmp++;
    if (ferr_cnt != 1) begin n_bad++; $display("FAIL frame_err_total: got %0d want 1", ferr_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] g, e;
    wait_ticks(1);
    send_frame(0, 9'h000, 8, 16);
    send_frame(0, 9'h0FF, 8, 16);
    wait_ticks(2);
    n_cmp++;
    if (got_q.size() != 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", got_q.size()); end
    for (int k = 0; k < 2; k++) begin
      if (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL b2b_data%0d: got %0h want %0h", k, g, e); end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [7:0] g, e;
    wait_ticks(1);
    send_bits(0, 9'h081, 3);
    drive(0, 1'b0);
    wait_ticks(8);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (dout !== 8'h00) begin n_bad++; $display("FAIL midrst_dout: got %0h want 00", dout); end
    n_cmp++;
    if ({rx_done_tick, frame_err, busy} !== 3'b000) begin
      n_bad++; $display("FAIL midrst_flags: got %b want 000", {rx_done_tick, frame_err, busy});
    end
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wait_ticks(4);
    n_cmp++;
    if (got_q.size() != 0) begin n_bad++; $display("FAIL midrst_pulses: got %0d want 0", got_q.size()); end
    send_frame(0, 9'h081, 8, 16);
    wait_ticks(2);
    n_cmp++;
    if (got_q.size() != 1) begin n_bad++; $display("FAIL midrst_resend_pulses: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL midrst_resend_data: got %0h want %0h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_param_variant;
    logic [6:0] g, e;
    int elapsed;
    got2_q.delete();
    wait_ticks(1);
    send_frame(1, 9'h055, 7, 32);
    wait_ticks(2);
    n_cmp++;
    if (got2_q.size() != 1) begin n_bad++; $display("FAIL param_pulses: got %0d want 1", got2_q.size()); end
    if (got2_q.size() > 0 && exp2_q.size() > 0) begin
      g = got2_q.pop_front(); e = exp2_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL param_data: got %0h want %0h", g, e); end
    end
    got2_q.delete(); exp2_q.delete();
    // start mid (8) + 7 data bits (112) + 32 stop ticks
    elapsed = done2_tick - fall_tick;
    n_cmp++;
    if (elapsed < 151 || elapsed > 153) begin
      n_bad++; $display("FAIL param_timing: got %0d ticks want 152", elapsed);
    end
    n_cmp++;
    if (ferr2_cnt != 0) begin n_bad++; $display("FAIL param_ferr: got %0d want 0", ferr2_cnt); end
  endtask

  task automatic test_exclusive;
    n_cmp++;
    if (overlap_cnt != 0) begin n_bad++; $display("FAIL done_ferr_overlap: got %0d want 0", overlap_cnt); end
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_valid;
    test_framing;
    test_back_to_back;
    test_reset_mid;
    test_param_variant;
    test_exclusive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
